// File: rtl/trap_controller.sv
// Trap controller: prioritises exceptions and machine interrupts, sequences the
// capture/vector/handler/return handshake with the CSR file and redirects fetch.
module trap_controller #(
    parameter logic [31:0] VEC_BASE = 32'h0000_0100,
    parameter bit          SYNC_EXT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        instr_valid,
    input  logic        instr_c,
    input  logic        ecall,
    input  logic        ebreak,
    input  logic        mret,
    input  logic        timer_cmp,
    input  logic        ext_irq,
    input  logic [3:0]  mie,
    input  logic [31:0] mepc,
    output logic        interrupt,
    output logic        stall,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [1:0]  mcause,
    output logic        in_handler,
    output logic        double_fault
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_VECTOR  = 3'd2,
        ST_HANDLER = 3'd3,
        ST_RETURN  = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_TIMER  = 2'd0;
    localparam logic [1:0] CAUSE_EXT    = 2'd1;
    localparam logic [1:0] CAUSE_ECALL  = 2'd2;
    localparam logic [1:0] CAUSE_EBREAK = 2'd3;

    function automatic logic [31:0] vector_target(input logic [31:0] base,
                                                  input logic [1:0]  cause);
        return base + {28'd0, cause, 2'b00};
    endfunction

    function automatic logic [31:0] return_target(input logic [31:0] epc,
                                                  input logic [2:0]  off);
        return epc + {29'd0, off};
    endfunction

    state_t      state_r;
    state_t      state_next_s;

    logic        ext_s;
    logic        timer_prev_r;
    logic        timer_pend_r;
    logic        timer_rise_s;
    logic        timer_avail_s;

    logic        trap_take_s;
    logic [1:0]  trap_cause_s;
    logic [2:0]  trap_off_s;
    logic [2:0]  ret_off_r;

    logic        interrupt_next_s;
    logic        stall_next_s;
    logic        flush_next_s;
    logic        redirect_next_s;
    logic [31:0] redirect_pc_next_s;
    logic        in_handler_next_s;

    // The retiring PC is captured by the CSR file itself; mie[2] is reserved.
    logic        unused_s;
    assign unused_s = ^{pc, mie[2]};

    generate
        if (SYNC_EXT) begin : g_ext_sync
            logic ext_meta_r;
            logic ext_sync_r;

            // Two-flop synchroniser for the asynchronous external request
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ext_meta_r <= 1'b0;
                    ext_sync_r <= 1'b0;
                end else begin
                    ext_meta_r <= ext_irq;
                    ext_sync_r <= ext_meta_r;
                end
            end

            assign ext_s = ext_sync_r;
        end else begin : g_ext_direct
            assign ext_s = ext_irq;
        end
    endgenerate

    // A fresh edge counts as pending in the same cycle so it can be taken immediately.
    assign timer_rise_s  = timer_cmp & ~timer_prev_r;
    assign timer_avail_s = timer_pend_r | timer_rise_s;

    // Trap arbitration, only evaluated while idle
    always_comb begin
        trap_take_s  = 1'b0;
        trap_cause_s = CAUSE_TIMER;
        trap_off_s   = 3'd0;
        if (state_r == ST_IDLE) begin
            if (instr_valid && ebreak) begin
                trap_take_s  = 1'b1;
                trap_cause_s = CAUSE_EBREAK;
                trap_off_s   = instr_c ? 3'd2 : 3'd4;
            end else if (instr_valid && ecall) begin
                trap_take_s  = 1'b1;
                trap_cause_s = CAUSE_ECALL;
                trap_off_s   = instr_c ? 3'd2 : 3'd4;
            end else if (ext_s && mie[1] && mie[3]) begin
                trap_take_s  = 1'b1;
                trap_cause_s = CAUSE_EXT;
                trap_off_s   = 3'd0;
            end else if (timer_avail_s && mie[0] && mie[3]) begin
                trap_take_s  = 1'b1;
                trap_cause_s = CAUSE_TIMER;
                trap_off_s   = 3'd0;
            end else begin
                trap_take_s  = 1'b0;
            end
        end else begin
            trap_take_s = 1'b0;
        end
    end

    // Timer edge detector and pending flag; taking the timer trap wins over a new edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_prev_r <= 1'b0;
            timer_pend_r <= 1'b0;
        end else begin
            timer_prev_r <= timer_cmp;
            if (trap_take_s && (trap_cause_s == CAUSE_TIMER)) begin
                timer_pend_r <= 1'b0;
            end else if (timer_rise_s) begin
                timer_pend_r <= 1'b1;
            end else begin
                timer_pend_r <= timer_pend_r;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:    state_next_s = trap_take_s ? ST_CAPTURE : ST_IDLE;
            ST_CAPTURE: state_next_s = ST_VECTOR;
            ST_VECTOR:  state_next_s = ST_HANDLER;
            ST_HANDLER: state_next_s = (instr_valid && mret) ? ST_RETURN : ST_HANDLER;
            ST_RETURN:  state_next_s = ST_IDLE;
            default:    state_next_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so every output leaves a flop
    always_comb begin
        interrupt_next_s   = 1'b0;
        stall_next_s       = 1'b0;
        flush_next_s       = 1'b0;
        redirect_next_s    = 1'b0;
        redirect_pc_next_s = redirect_pc;
        in_handler_next_s  = 1'b0;
        case (state_next_s)
            ST_IDLE: begin
                in_handler_next_s = 1'b0;
            end
            ST_CAPTURE: begin
                interrupt_next_s = 1'b1;
                stall_next_s     = 1'b1;
                flush_next_s     = 1'b1;
            end
            ST_VECTOR: begin
                stall_next_s       = 1'b1;
                redirect_next_s    = 1'b1;
                redirect_pc_next_s = vector_target(VEC_BASE, mcause);
            end
            ST_HANDLER: begin
                in_handler_next_s = 1'b1;
            end
            ST_RETURN: begin
                stall_next_s       = 1'b1;
                redirect_next_s    = 1'b1;
                redirect_pc_next_s = return_target(mepc, ret_off_r);
            end
            default: begin
                in_handler_next_s = 1'b0;
            end
        endcase
    end

    // Registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            interrupt   <= 1'b0;
            stall       <= 1'b0;
            flush       <= 1'b0;
            redirect    <= 1'b0;
            redirect_pc <= 32'd0;
            in_handler  <= 1'b0;
        end else begin
            interrupt   <= interrupt_next_s;
            stall       <= stall_next_s;
            flush       <= flush_next_s;
            redirect    <= redirect_next_s;
            redirect_pc <= redirect_pc_next_s;
            in_handler  <= in_handler_next_s;
        end
    end

    // Cause and return offset latched when a trap is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcause    <= 2'd0;
            ret_off_r <= 3'd0;
        end else if (trap_take_s) begin
            mcause    <= trap_cause_s;
            ret_off_r <= trap_off_s;
        end else begin
            mcause    <= mcause;
            ret_off_r <= ret_off_r;
        end
    end

    // Sticky flag for a synchronous exception raised inside the handler
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            double_fault <= 1'b0;
        end else if ((state_r == ST_HANDLER) && instr_valid && (ecall || ebreak)) begin
            double_fault <= 1'b1;
        end else begin
            double_fault <= double_fault;
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: hand-computed vectors for trap entry, vectoring,
// MRET return, priority, pending timer, masking, double fault and mid-operation reset.
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        instr_valid, instr_c, ecall, ebreak, mret;
    logic        timer_cmp, ext_irq;
    logic [3:0]  mie;
    logic [31:0] mepc;
    logic        interrupt, stall, flush, redirect;
    logic [31:0] redirect_pc;
    logic [1:0]  mcause;
    logic        in_handler, double_fault;

    int n_checks = 0;
    int n_pass   = 0;

    // Output bundle order {interrupt, stall, flush, redirect, in_handler}
    localparam logic [4:0] O_IDLE    = 5'b00000;
    localparam logic [4:0] O_CAPTURE = 5'b11100;
    localparam logic [4:0] O_VECTOR  = 5'b01010;
    localparam logic [4:0] O_HANDLER = 5'b00001;
    localparam logic [4:0] O_RETURN  = 5'b01010;

    always #5 clk = ~clk;

    trap_controller dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .instr_valid  (instr_valid),
        .instr_c      (instr_c),
        .ecall        (ecall),
        .ebreak       (ebreak),
        .mret         (mret),
        .timer_cmp    (timer_cmp),
        .ext_irq      (ext_irq),
        .mie          (mie),
        .mepc         (mepc),
        .interrupt    (interrupt),
        .stall        (stall),
        .flush        (flush),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .mcause       (mcause),
        .in_handler   (in_handler),
        .double_fault (double_fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic [4:0] exp);
        check(tag, {27'd0, interrupt, stall, flush, redirect, in_handler}, {27'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_instr();
        instr_valid = 1'b0;
        instr_c     = 1'b0;
        ecall       = 1'b0;
        ebreak      = 1'b0;
        mret        = 1'b0;
    endtask

    task automatic do_mret(input string tag, input logic [31:0] epc, input logic [31:0] exp_pc);
        mepc        = epc;
        instr_valid = 1'b1;
        mret        = 1'b1;
        tick();
        clear_instr();
        check_ctl({tag, "_ret_ctl"}, O_RETURN);
        check({tag, "_ret_pc"}, redirect_pc, exp_pc);
        tick();
        check_ctl({tag, "_idle_ctl"}, O_IDLE);
    endtask

    initial begin
        rst       = 1'b1;
        pc        = 32'd0;
        clear_instr();
        timer_cmp = 1'b0;
        ext_irq   = 1'b0;
        mie       = 4'h0;
        mepc      = 32'd0;
        tick();
        tick();
        check_ctl("reset_ctl", O_IDLE);
        check("reset_rpc", redirect_pc, 32'd0);
        check("reset_cause", {30'd0, mcause}, 32'd0);
        check("reset_df", {31'd0, double_fault}, 32'd0);
        rst = 1'b0;

        // Timer edge: interrupt one cycle later, vector 0x100 the next
        mie       = 4'hF;
        pc        = 32'h40;
        timer_cmp = 1'b1;
        tick();
        check_ctl("tmr_capture", O_CAPTURE);
        check("tmr_cause", {30'd0, mcause}, 32'd0);
        tick();
        check_ctl("tmr_vector", O_VECTOR);
        check("tmr_vec_pc", redirect_pc, 32'h100);
        tick();
        check_ctl("tmr_handler", O_HANDLER);
        do_mret("tmr", 32'h40, 32'h40);
        tick();
        tick();
        check_ctl("tmr_level_no_retrigger", O_IDLE);
        timer_cmp = 1'b0;
        tick();

        // ECALL, 32-bit instruction
        pc          = 32'h80;
        instr_valid = 1'b1;
        ecall       = 1'b1;
        tick();
        clear_instr();
        check_ctl("ecall_capture", O_CAPTURE);
        check("ecall_cause", {30'd0, mcause}, 32'd2);
        tick();
        check("ecall_vec_pc", redirect_pc, 32'h108);
        tick();
        check_ctl("ecall_handler", O_HANDLER);
        do_mret("ecall", 32'h80, 32'h84);

        // C.EBREAK, 16-bit instruction
        pc          = 32'h90;
        instr_valid = 1'b1;
        ebreak      = 1'b1;
        instr_c     = 1'b1;
        tick();
        clear_instr();
        check("ebreak_cause", {30'd0, mcause}, 32'd3);
        tick();
        check_ctl("ebreak_vector", O_VECTOR);
        check("ebreak_vec_pc", redirect_pc, 32'h10C);
        tick();
        do_mret("ebreak", 32'h90, 32'h92);

        // External and timer edge together: external wins, timer stays pending
        ext_irq = 1'b1;
        tick();
        tick();
        timer_cmp = 1'b1;
        tick();
        ext_irq = 1'b0;
        check_ctl("ext_capture", O_CAPTURE);
        check("ext_cause", {30'd0, mcause}, 32'd1);
        tick();
        check("ext_vec_pc", redirect_pc, 32'h104);
        tick();
        check_ctl("ext_handler", O_HANDLER);
        tick();
        check_ctl("ext_no_nesting", O_HANDLER);
        do_mret("ext", 32'h200, 32'h200);
        tick();
        check_ctl("pend_capture", O_CAPTURE);
        check("pend_cause", {30'd0, mcause}, 32'd0);
        tick();
        check("pend_vec_pc", redirect_pc, 32'h100);
        tick();
        do_mret("pend", 32'h300, 32'h300);
        tick();
        check_ctl("pend_cleared", O_IDLE);
        timer_cmp = 1'b0;
        tick();

        // Global enable off: edge is remembered until mie[3] rises
        mie       = 4'h7;
        timer_cmp = 1'b1;
        tick();
        check_ctl("masked_no_trap", O_IDLE);
        tick();
        check_ctl("masked_still_idle", O_IDLE);
        mie = 4'hF;
        tick();
        check_ctl("unmask_capture", O_CAPTURE);
        check("unmask_cause", {30'd0, mcause}, 32'd0);
        tick();
        tick();
        check_ctl("unmask_handler", O_HANDLER);

        // ECALL inside the handler sets a sticky double fault
        instr_valid = 1'b1;
        ecall       = 1'b1;
        tick();
        clear_instr();
        check("df_set", {31'd0, double_fault}, 32'd1);
        check_ctl("df_stay_handler", O_HANDLER);
        do_mret("df", 32'h400, 32'h400);
        check("df_sticky", {31'd0, double_fault}, 32'd1);
        timer_cmp = 1'b0;
        tick();

        // Reset while in VECTOR
        instr_valid = 1'b1;
        ecall       = 1'b1;
        tick();
        clear_instr();
        tick();
        check_ctl("pre_rst_vector", O_VECTOR);
        rst = 1'b1;
        #1;
        check_ctl("rst_async_ctl", O_IDLE);
        tick();
        check_ctl("rst_edge_ctl", O_IDLE);
        check("rst_edge_rpc", redirect_pc, 32'd0);
        check("rst_edge_df", {31'd0, double_fault}, 32'd0);
        check("rst_edge_cause", {30'd0, mcause}, 32'd0);
        rst = 1'b0;
        tick();

        // MRET while idle is ignored
        instr_valid = 1'b1;
        mret        = 1'b1;
        tick();
        check_ctl("mret_idle_ignored", O_IDLE);

        // MRET together with ECALL while idle: the trap wins
        ecall = 1'b1;
        tick();
        clear_instr();
        check_ctl("mret_vs_trap", O_CAPTURE);
        check("mret_vs_trap_cause", {30'd0, mcause}, 32'd2);
        tick();
        check("mret_vs_trap_vec", redirect_pc, 32'h108);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
